// File: rtl/vga_timing_pkg.sv
// Raster geometry for 640x480 @ 800x525 and the packed pixel byte layout
// shared by the scanout and its FIFO.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int PIX_R_HI = 7;
    localparam int PIX_R_LO = 6;
    localparam int PIX_G_HI = 5;
    localparam int PIX_G_LO = 4;
    localparam int PIX_B_HI = 3;
    localparam int PIX_B_LO = 2;

    typedef struct packed {
        logic [1:0] red;
        logic [1:0] green;
        logic [1:0] blue;
    } pix_t;

    function automatic pix_t unpack_pixel(input logic [7:0] b);
        pix_t p;
        p.red   = b[PIX_R_HI:PIX_R_LO];
        p.green = b[PIX_G_HI:PIX_G_LO];
        p.blue  = b[PIX_B_HI:PIX_B_LO];
        return p;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with an extra pointer bit so full and empty are distinct;
// the head entry is read straight from storage, so a fresh push is poppable next cycle.
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == FULL_LEVEL);
    assign empty   = (wr_ptr == rd_ptr);
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    // A pop frees the slot the push lands in, so a full FIFO may take both.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: buffers producer pixel bytes, drains one per visible clock,
// and generates sync timing plus the frame-restart pulse for the producer.
module vga_scanout
    import vga_timing_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int FIFO_AW     = 4,
    parameter int UNDERFLOW_W = 16,
    // Vertical geometry can be shortened for reduced-height rasters.
    parameter int V_ACT       = V_VISIBLE,
    parameter int V_FPORCH    = V_FP,
    parameter int V_SLEN      = V_SYNC,
    parameter int V_BPORCH    = V_BP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             data_i,
    input  logic                   stb_i,
    output logic                   ack_i,
    output logic                   sync,
    output logic                   hsync,
    output logic                   vsync,
    output logic [1:0]             red,
    output logic [1:0]             green,
    output logic [1:0]             blue,
    output logic [UNDERFLOW_W-1:0] underflow_cnt,
    output logic [FIFO_AW:0]       fifo_level
);

    localparam logic [9:0] HV       = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] HT_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] VV       = 10'(V_ACT);
    localparam logic [9:0] VS_START = 10'(V_ACT + V_FPORCH);
    localparam logic [9:0] VS_END   = 10'(V_ACT + V_FPORCH + V_SLEN);
    localparam logic [9:0] VT_LAST  = 10'(V_ACT + V_FPORCH + V_SLEN + V_BPORCH - 1);

    logic [9:0] sx;
    logic [9:0] sy;
    logic       visible;
    logic       line_end;
    logic       frame_end;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       accept;
    pix_t       in_pix;
    pix_t       head_pix;
    logic       unused_pad;

    assign visible    = (sx < HV) && (sy < VV);
    assign line_end   = (sx == HT_LAST);
    assign frame_end  = line_end && (sy == VT_LAST);
    assign in_pix     = unpack_pixel(data_i);
    assign unused_pad = ^data_i[1:0];

    // Handshake: a byte is taken when stb_i is high, no ack is in flight and
    // there is room (or a pop this cycle makes room); ack_i then pulses for
    // exactly one cycle, and the producer may keep stb_i high during it.
    assign pop    = visible && !fifo_empty;
    assign accept = stb_i && !ack_i && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            sx <= '0;
            sy <= '0;
        end else if (line_end) begin
            sx <= '0;
            sy <= (sy == VT_LAST) ? 10'd0 : sy + 10'd1;
        end else begin
            sx <= sx + 10'd1;
        end
    end

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW),
        .W     ($bits(pix_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .wdata (in_pix),
        .rdata (head_pix),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_i         <= 1'b0;
            sync          <= 1'b0;
            hsync         <= 1'b1;
            vsync         <= 1'b1;
            red           <= '0;
            green         <= '0;
            blue          <= '0;
            underflow_cnt <= '0;
        end else begin
            ack_i <= accept;
            sync  <= frame_end;
            hsync <= !((sx >= HS_START) && (sx < HS_END));
            vsync <= !((sy >= VS_START) && (sy < VS_END));
            red   <= pop ? head_pix.red   : 2'b00;
            green <= pop ? head_pix.green : 2'b00;
            blue  <= pop ? head_pix.blue  : 2'b00;
            if (visible && fifo_empty && (underflow_cnt != {UNDERFLOW_W{1'b1}}))
                underflow_cnt <= underflow_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shortened 800x16 raster with a reference
// model and an expected-pixel queue checked on every clock.
module tb_vga_scanout;

    localparam int VA   = 8;
    localparam int VF   = 2;
    localparam int VS   = 2;
    localparam int VB   = 4;
    localparam int VT   = VA + VF + VS + VB;
    localparam int UW   = 12;
    localparam int DEP  = 16;
    localparam int UMAX = (1 << UW) - 1;

    logic          clk;
    logic          rst;
    logic [7:0]    data_i;
    logic          stb_i;
    logic          ack_i;
    logic          sync;
    logic          hsync;
    logic          vsync;
    logic [1:0]    red;
    logic [1:0]    green;
    logic [1:0]    blue;
    logic [UW-1:0] underflow_cnt;
    logic [4:0]    fifo_level;

    vga_scanout #(
        .FIFO_DEPTH  (DEP),
        .FIFO_AW     (4),
        .UNDERFLOW_W (UW),
        .V_ACT       (VA),
        .V_FPORCH    (VF),
        .V_SLEN      (VS),
        .V_BPORCH    (VB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_i        (data_i),
        .stb_i         (stb_i),
        .ack_i         (ack_i),
        .sync          (sync),
        .hsync         (hsync),
        .vsync         (vsync),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .underflow_cnt (underflow_cnt),
        .fifo_level    (fifo_level)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state and scoreboard
    logic [7:0] exp_q[$];
    int         m_sx, m_sy, m_level, m_under;
    bit         m_ack;
    logic       e_ack, e_sync, e_hs, e_vs;
    logic [5:0] e_rgb;

    int vectors, miscompares;
    bit prod_mode;
    int ack_cnt, hs_low_cnt, vs_low_cnt, sync_cnt;
    bit seen_full_pushpop, seen_30;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict from pre-edge state, advance, then compare all outputs.
    task automatic step();
        bit         vis, pop, acc;
        int         psx, psy;
        logic [7:0] din, b;
        vis = (m_sx < 640) && (m_sy < VA);
        pop = vis && (m_level > 0);
        acc = stb_i && !m_ack && ((m_level < DEP) || pop);
        psx = m_sx;
        psy = m_sy;
        din = data_i;
        if (!rst && acc && pop && m_level == DEP) seen_full_pushpop = 1'b1;
        @(posedge clk);
        #1;
        if (rst) begin
            m_sx = 0; m_sy = 0; m_level = 0; m_under = 0; m_ack = 1'b0;
            exp_q.delete();
            e_ack = 1'b0; e_sync = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = 6'd0;
        end else begin
            e_ack  = acc;
            e_sync = (psx == 799) && (psy == VT - 1);
            e_hs   = !((psx >= 656) && (psx < 752));
            e_vs   = !((psy >= VA + VF) && (psy < VA + VF + VS));
            e_rgb  = 6'd0;
            if (pop) begin
                b = exp_q.pop_front();
                e_rgb = {b[7:6], b[5:4], b[3:2]};
                if (b == 8'h30) begin
                    seen_30 = 1'b1;
                    check("byte30_rgb", {26'd0, red, green, blue}, {26'd0, 6'b00_11_00});
                end
            end
            if (vis && m_level == 0 && m_under < UMAX) m_under++;
            if (acc) exp_q.push_back(din);
            m_level = m_level + int'(acc) - int'(pop);
            m_ack   = acc;
            if (m_sx == 799) begin
                m_sx = 0;
                m_sy = (m_sy == VT - 1) ? 0 : m_sy + 1;
            end else begin
                m_sx++;
            end
        end
        check("ack_i", {31'd0, ack_i}, {31'd0, e_ack});
        check("sync", {31'd0, sync}, {31'd0, e_sync});
        check("hsync", {31'd0, hsync}, {31'd0, e_hs});
        check("vsync", {31'd0, vsync}, {31'd0, e_vs});
        check("rgb", {26'd0, red, green, blue}, {26'd0, e_rgb});
        check("underflow_cnt", {20'd0, underflow_cnt}, m_under);
        check("fifo_level", {27'd0, fifo_level}, m_level);
        if (ack_i) ack_cnt++;
        if (!hsync) hs_low_cnt++;
        if (!vsync) vs_low_cnt++;
        if (sync) sync_cnt++;
        if (prod_mode && ack_i) data_i = data_i + 8'h04;
    endtask

    initial begin
        int budget;
        vectors = 0; miscompares = 0; prod_mode = 1'b0;
        seen_full_pushpop = 1'b0; seen_30 = 1'b0;
        m_sx = 0; m_sy = 0; m_level = 0; m_under = 0; m_ack = 1'b0;
        rst = 1'b1; stb_i = 1'b0; data_i = 8'h00;

        // reset
        step();
        step();
        rst = 1'b0;

        // idle frame: no acks, sync widths, underflow saturates
        ack_cnt = 0; vs_low_cnt = 0;
        for (int line = 0; line < VT; line++) begin
            hs_low_cnt = 0;
            repeat (800) step();
            check("hsync_low_cycles", hs_low_cnt, 96);
        end
        check("idle_ack_count", ack_cnt, 0);
        check("vsync_low_cycles", vs_low_cnt, 2 * 800);
        check("underflow_saturated", {20'd0, underflow_cnt}, UMAX);

        // frame 2: fill FIFO during vertical blanking with a constant byte
        sync_cnt = 0;
        while (m_sy < VA) step();
        stb_i = 1'b1; data_i = 8'hFC; ack_cnt = 0;
        repeat (40) step();
        check("fill_ack_count", ack_cnt, 16);
        check("fill_level", {27'd0, fifo_level}, 16);
        ack_cnt = 0;
        repeat (20) step();
        check("stall_ack_count", ack_cnt, 0);

        // incrementing producer; FIFO stays full into the next visible area
        data_i = 8'h04; prod_mode = 1'b1;
        while (!(m_sx == 799 && m_sy == VT - 1)) step();
        step();
        check("sync_pulse", {31'd0, sync}, 32'd1);
        step();
        check("sync_one_cycle", {31'd0, sync}, 32'd0);
        repeat (3 * 800) step();
        check("sync_count", sync_cnt, 1);
        check("full_pushpop_seen", {31'd0, seen_full_pushpop}, 32'd1);
        check("byte30_seen", {31'd0, seen_30}, 32'd1);

        // reset mid-line with 10 buffered pixels and the strobe still high
        budget = 5000;
        while (!(m_level == 10 && m_sx < 640 && m_sy < VA) && budget > 0) begin
            step();
            budget--;
        end
        check("level10_reached", {31'd0, budget > 0}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_level", {27'd0, fifo_level}, 0);
        check("rst_ack", {31'd0, ack_i}, 0);
        check("rst_hsync", {31'd0, hsync}, 1);
        check("rst_vsync", {31'd0, vsync}, 1);
        check("rst_rgb", {26'd0, red, green, blue}, 0);
        check("rst_underflow", {20'd0, underflow_cnt}, 0);
        repeat (1000) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
